// File: rtl/axi_burst_rd_master.sv
// AXI3 read initiator: splits one (address, beat count) command into INCR bursts of at most
// 16 beats that never cross a 4 KB page, and streams the returned beats out in order.
// The optional rresp/rid/rlast checker and its o_err port are enabled by CNN_RD_ERR_CHK_EN.
module axi_burst_rd_master #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int ID_MAX_WIDTH = 12,
   parameter int RD_ID        = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [15:0]             cmd_beats,
   output logic [ID_MAX_WIDTH-1:0] arid,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [3:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arbrust,
   output logic [1:0]              arlock,
   output logic [3:0]              arcache,
   output logic [2:0]              arprot,
   output logic [3:0]              arqos,
   output logic [3:0]              arregion,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [ID_MAX_WIDTH-1:0] rid,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready,
   output logic [DATA_WIDTH-1:0]   o_data,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_busy,
   output logic                    o_done
`ifdef CNN_RD_ERR_CHK_EN
  ,output logic                    o_err
`endif
);

   localparam int SIZE = $clog2(DATA_WIDTH / 8);

   // Handshake rule on every channel: a transfer happens in the cycle where valid and ready
   // are both high at the rising edge; a valid source holds its payload until that cycle.
   typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [15:0]             rem_q, rem_d;
   logic [3:0]              arlen_q, arlen_d;
   logic [3:0]              beat_q, beat_d;
   logic                    done_q, done_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    load_burst;
   logic                    last_beat;
   logic [4:0]              blen_cur;
`ifdef CNN_RD_ERR_CHK_EN
   logic                    err_q, err_d;
`else
   logic                    unused_rd_sideband;
   assign unused_rd_sideband = ^{rresp, rid, rlast};
`endif

   // Burst length minus one: limited by what is left, the AXI3 16-beat cap and the 4 KB page.
   function automatic logic [3:0] calc_len(input logic [15:0] rem, input logic [11:0] off);
      logic [12:0] room;
      logic [16:0] b;
      room = (13'd4096 - {1'b0, off}) >> SIZE;
      b    = {1'b0, rem};
      if (b > 17'd16) b = 17'd16;
      if (b > {4'b0, room}) b = {4'b0, room};
      return 4'(b - 17'd1);
   endfunction

   assign blen_cur  = {1'b0, arlen_q} + 5'd1;
   assign last_beat = (beat_q == arlen_q);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      arlen_d    = arlen_q;
      beat_d     = beat_q;
      done_d     = 1'b0;
      load_burst = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      o_valid    = 1'b0;
`ifdef CNN_RD_ERR_CHK_EN
      err_d      = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
`ifdef CNN_RD_ERR_CHK_EN
               err_d = 1'b0;
`endif
               if (cmd_beats != 16'd0) begin
                  addr_d     = cmd_addr;
                  rem_d      = cmd_beats;
                  load_burst = 1'b1;
                  state_d    = ST_AR;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_AR: begin
            arvalid = 1'b1;
            if (arready) begin
               beat_d  = 4'd0;
               state_d = ST_R;
            end
         end
         ST_R: begin
            o_valid = rvalid;
            rready  = i_ready;
            if (rvalid && i_ready) begin
`ifdef CNN_RD_ERR_CHK_EN
               if ((rresp != 2'b00) || (rid != ID_MAX_WIDTH'(RD_ID)) || (rlast != last_beat))
                  err_d = 1'b1;
`endif
               // The local beat counter, not rlast, decides where a burst ends.
               if (last_beat) begin
                  addr_d = addr_q + (ADDR_WIDTH'(blen_cur) << SIZE);
                  rem_d  = rem_q - {11'd0, blen_cur};
                  if (rem_d == 16'd0) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d    = ST_AR;
                     load_burst = 1'b1;
                  end
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load_burst) arlen_d = calc_len(rem_d, addr_d[11:0]);
      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         arlen_q     <= '0;
         beat_q      <= '0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
`ifdef CNN_RD_ERR_CHK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         arlen_q     <= arlen_d;
         beat_q      <= beat_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
`ifdef CNN_RD_ERR_CHK_EN
         err_q       <= err_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign o_busy    = (state_q != ST_IDLE);
   assign o_done    = done_q;
   assign o_data    = rdata;
   assign araddr    = addr_q;
   assign arlen     = arlen_q;
   assign arid      = ID_MAX_WIDTH'(RD_ID);
   assign arsize    = 3'(SIZE);
   assign arbrust   = 2'b01;
   assign arlock    = 2'b00;
   assign arcache   = 4'b0011;
   assign arprot    = 3'b000;
   assign arqos     = 4'b0000;
   assign arregion  = 4'b0000;
`ifdef CNN_RD_ERR_CHK_EN
   assign o_err     = err_q;
`endif

endmodule

// File: tb/tb_axi_burst_rd_master.sv
// Bench for axi_burst_rd_master: memory-model AXI slave, stream sink, burst-splitting
// reference model, table of directed commands, hand corner cases and random commands.
module tb_axi_burst_rd_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_beats;
   logic [11:0] arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arbrust, arlock;
   logic [3:0]  arcache, arqos, arregion;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [11:0] rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic [31:0] o_data;
   logic        o_valid, i_ready, o_busy, o_done;
`ifdef CNN_RD_ERR_CHK_EN
   logic        o_err;
`endif

   axi_burst_rd_master dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arbrust(arbrust), .arlock(arlock),
      .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
      .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rvalid(rvalid), .rready(rready), .o_data(o_data),
      .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
`ifdef CNN_RD_ERR_CHK_EN
      .o_err(o_err),
`endif
      .o_done(o_done)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];     // expected stream words
   logic [35:0] ar_exp[$];    // expected {araddr, arlen}
   logic [35:0] r_pend[$];    // accepted bursts the slave still has to return
   int n_cmp = 0;
   int n_err = 0;
   int ar_total = 0, ar_mark = 0, done_total = 0, stall_seen = 0;
   logic [3:0] first_len_seen;
   int ar_stall = 0, ar_wait = 0;
   int rv_pct = 100, ir_pct = 100;
   int r_idx = 0, cmd_beat = 0, err_at = -1;
   logic r_hs = 1'b0, ar_hold = 1'b0;
   logic [35:0] ar_prev;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0F96;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference model: page-bounded, 16-capped splitting plus the linear word sequence.
   task automatic model_cmd(input logic [31:0] addr, input int beats);
      int rem;
      int room;
      int b;
      logic [31:0] a;
      rem = beats;
      a   = addr;
      for (int i = 0; i < beats; i++) exp_q.push_back(mem_word(addr + 32'(4 * i)));
      while (rem > 0) begin
         room = (4096 - int'(a % 4096)) / 4;
         b = rem;
         if (b > 16) b = 16;
         if (b > room) b = room;
         ar_exp.push_back({a, 4'(b - 1)});
         a   = a + 32'(4 * b);
         rem = rem - b;
      end
   endtask

   // ---------------- slave + monitor ----------------
   initial begin
      logic [35:0] cur;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00; rid = '0;
      i_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (arvalid && arready) begin
               ar_total++;
               if (ar_total == ar_mark + 1) first_len_seen = arlen;
               if (ar_exp.size() == 0) fail_now("unexpected_ar");
               else check("ar_addr_len", {araddr, arlen}, ar_exp.pop_front());
               r_pend.push_back({araddr, arlen});
               ar_wait = 0;
            end
            if (ar_hold) check("ar_stable", {arvalid, araddr, arlen}, {1'b1, ar_prev});
            ar_hold = arvalid && !arready;
            ar_prev = {araddr, arlen};
            if (arvalid && !arready) stall_seen++;
            r_hs = rvalid && rready;
            if (r_hs) begin
               cur = r_pend[0];
               cmd_beat++;
               if (r_idx == int'(cur[3:0])) begin
                  void'(r_pend.pop_front());
                  r_idx = 0;
               end else r_idx++;
            end
            if (rready) check("rready_needs_iready", i_ready, 1'b1);
            if (o_valid) begin
               check("o_valid_is_rvalid", rvalid, 1'b1);
               check("rready_eq_iready", rready, i_ready);
               check("o_data_passthru", o_data, rdata);
            end
            if (o_valid && i_ready) begin
               if (exp_q.size() == 0) fail_now("extra_beat");
               else check("stream_data", o_data, exp_q.pop_front());
            end
            if (o_done) done_total++;
            if (o_busy && cmd_ready) fail_now("cmd_ready_while_busy");
         end
         @(posedge clk);
         #1;
         arready = arvalid && (ar_wait >= ar_stall);
         if (arvalid && !arready) ar_wait++;
         if (!(rvalid && !r_hs)) begin
            if (r_pend.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
               cur    = r_pend[0];
               rvalid = 1'b1;
               rdata  = mem_word(cur[35:4] + 32'(4 * r_idx));
               rlast  = (r_idx == int'(cur[3:0]));
               rresp  = (cmd_beat == err_at) ? 2'b10 : 2'b00;
            end else begin
               rvalid = 1'b0;
               rlast  = 1'b0;
               rresp  = 2'b00;
               rdata  = $urandom;
            end
         end
         r_hs    = 1'b0;
         i_ready = ($urandom_range(0, 99) < ir_pct);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input logic [31:0] a, input int b);
      logic acc;
      acc = 1'b0;
      model_cmd(a, b);
      cmd_addr  = a;
      cmd_beats = 16'(b);
      cmd_valid = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (cmd_ready) begin
            acc = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (!acc) fail_now("cmd_accept_timeout");
   endtask

   task automatic wait_done(input int target);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         @(posedge clk);
         #2;
         if (done_total >= target) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail_now("done_timeout");
      repeat (3) @(posedge clk);
      #2;
      check("done_pulse_count", 64'(done_total), 64'(target));
      check("idle_not_busy", o_busy, 1'b0);
      check("stream_drained", 64'(exp_q.size()), 64'd0);
      check("ars_drained", 64'(ar_exp.size()), 64'd0);
   endtask

   typedef struct {
      logic [31:0] addr;
      int          beats;
      int          n_ar;
      logic [3:0]  first_len;
   } vec_t;

   vec_t vecs[7];

   // ---------------- test sequence ----------------
   initial begin
      int base;
      logic [31:0] a;
      vecs[0] = '{32'h4000_0000, 16, 1, 4'd15};
      vecs[1] = '{32'h4000_0000, 40, 3, 4'd15};
      vecs[2] = '{32'h4000_0FF0,  8, 2, 4'd3};
      vecs[3] = '{32'h4000_0FFC, 20, 3, 4'd0};
      vecs[4] = '{32'h4000_1F00, 64, 4, 4'd15};
      vecs[5] = '{32'h0000_0004,  1, 1, 4'd0};
      vecs[6] = '{32'h4000_0000,  0, 0, 4'd0};

      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_arvalid", arvalid, 1'b0);
      check("rst_rready", rready, 1'b0);
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_o_busy", o_busy, 1'b0);
      check("rst_o_done", o_done, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_araddr", araddr, 32'h0);
      check("rst_arlen", arlen, 4'h0);
      check("const_arsize", arsize, 3'd2);
      check("const_arburst", arbrust, 2'b01);
      check("const_arcache", arcache, 4'b0011);
      check("const_arid", arid, 12'h0);
      check("const_misc", {arlock, arprot, arqos, arregion}, 13'h0);
`ifdef CNN_RD_ERR_CHK_EN
      check("rst_o_err", o_err, 1'b0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed table
      rv_pct = 70;
      ir_pct = 80;
      for (int i = 0; i < 7; i++) begin
         ar_stall = i % 3;
         ar_mark  = ar_total;
         base     = done_total;
         send_cmd(vecs[i].addr, vecs[i].beats);
         wait_done(base + 1);
         check($sformatf("vec%0d_n_ar", i), 64'(ar_total - ar_mark), 64'(vecs[i].n_ar));
         if (vecs[i].n_ar > 0)
            check($sformatf("vec%0d_first_len", i), first_len_seen, vecs[i].first_len);
      end

      // arready withheld for 5 cycles: one handshake, stable request throughout
      ar_stall   = 5;
      stall_seen = 0;
      ar_mark    = ar_total;
      base       = done_total;
      send_cmd(32'h4000_0000, 16);
      wait_done(base + 1);
      check("stall_cycles", 64'(stall_seen), 64'd5);
      check("stall_one_ar", 64'(ar_total - ar_mark), 64'd1);
      ar_stall = 0;

      // Zero-beat command: done on the very next cycle, never busy, no AR
      ar_mark = ar_total;
      base    = done_total;
      send_cmd(32'h4000_0100, 0);
      @(negedge clk);
      check("zero_done_next", o_done, 1'b1);
      check("zero_not_busy", o_busy, 1'b0);
      wait_done(base + 1);
      check("zero_no_ar", 64'(ar_total - ar_mark), 64'd0);

      // Second command held on cmd_valid while the first is running
      base = done_total;
      send_cmd(32'h4000_2000, 8);
      @(negedge clk);
      check("busy_after_accept", o_busy, 1'b1);
      @(posedge clk);
      #1;
      send_cmd(32'h4000_3FF8, 6);
      wait_done(base + 2);

`ifdef CNN_RD_ERR_CHK_EN
      // Error response on beat 3: sticky flag, transfer still completes, cleared by next accept
      base     = done_total;
      cmd_beat = 0;
      err_at   = 3;
      send_cmd(32'h4000_5000, 8);
      wait_done(base + 1);
      check("err_sticky", o_err, 1'b1);
      err_at = -1;
      base   = done_total;
      send_cmd(32'h4000_6000, 4);
      @(negedge clk);
      check("err_cleared", o_err, 1'b0);
      wait_done(base + 1);
      check("err_stays_clear", o_err, 1'b0);
`endif

      // Random commands, biased toward the 4 KB page edge
      for (int i = 0; i < 20; i++) begin
         a = {4'h4, 16'($urandom), 12'($urandom_range(0, 1023) << 2)};
         if ($urandom_range(0, 2) == 0) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 20));
         ar_stall = $urandom_range(0, 3);
         rv_pct   = $urandom_range(30, 100);
         ir_pct   = $urandom_range(30, 100);
         base     = done_total;
         send_cmd(a, $urandom_range(0, 50));
         wait_done(base + 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
